// File: rtl/l9_pkg.sv
// Shared layer-9 definitions: address geometry, group stride, sequencer states.
package l9_pkg;

    localparam int L9_ADDR_W  = 10;
    localparam int L9_COORD_W = 4;
    localparam int L9_GRP_W   = 2;

    // Each channel group sits 8 rows further down the Y5 half of the address.
    localparam logic [4:0] L9_GRP_STRIDE = 5'd8;

    localparam int L9_NGRP2 = 2;
    localparam int L9_NGRP4 = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        DRAIN = 2'd2,
        DONE  = 2'd3
    } l9_state_t;

endpackage

// File: rtl/bram1_wr_seq_l9_if.sv
// Pixel-in / BRAM1-write bus of the layer-9 write sequencer.
interface bram1_wr_seq_l9_if
    import l9_pkg::*;
#(
    parameter int DATA_W = 16
);

    logic                 start;
    logic                 mode4;
    logic                 in_valid;
    logic [DATA_W-1:0]    in_data;
    logic                 in_ready;
    logic                 bram1_we;
    logic [L9_ADDR_W-1:0] bram1_addr;
    logic [DATA_W-1:0]    bram1_din;
    logic                 busy;
    logic                 done;
    logic                 err;

    // Controller / PE-array side.
    modport master (
        output start, mode4, in_valid, in_data,
        input  in_ready, bram1_we, bram1_addr, bram1_din, busy, done, err
    );

    // Sequencer side.
    modport slave (
        input  start, mode4, in_valid, in_data,
        output in_ready, bram1_we, bram1_addr, bram1_din, busy, done, err
    );

endinterface

// File: rtl/bram1_wr_addr_l9.sv
// Combinational (x,y,g) -> BRAM1 address, mirror of the layer-9 read map.
module bram1_wr_addr_l9
    import l9_pkg::*;
(
    input  logic [L9_COORD_W-1:0] x,
    input  logic [L9_COORD_W-1:0] y,
    input  logic [L9_GRP_W-1:0]   g,
    output logic [L9_ADDR_W-1:0]  addr
);

    logic [4:0] x5;
    logic [4:0] y5;

    // Y5 = y + 8*g; with y <= 7 the 5-bit sum never carries.
    always_comb begin
        x5   = {1'b0, x};
        y5   = {1'b0, y} + (L9_GRP_STRIDE * {3'b000, g});
        addr = {x5, y5};
    end

endmodule

// File: rtl/bram1_wr_seq_l9.sv
// Layer-9 BRAM1 write sequencer: accepts pixels, walks y/x/group, writes BRAM1.
module bram1_wr_seq_l9
    import l9_pkg::*;
#(
    parameter int DATA_W = 16,
    parameter int DIM    = 8
)(
    input  logic             clk,
    input  logic             rst,
    bram1_wr_seq_l9_if.slave bus
);

    localparam logic [L9_COORD_W-1:0] LAST_C = L9_COORD_W'(DIM - 1);

    l9_state_t             state;
    logic [L9_COORD_W-1:0] x, y;
    logic [L9_GRP_W-1:0]   g;
    logic                  mode4_q;
    logic                  ready_q, busy_q, done_q, err_q;
    logic                  we_q;
    logic [L9_ADDR_W-1:0]  addr_q;
    logic [DATA_W-1:0]     din_q;

    logic                  accept;
    logic                  last_pix;
    logic [L9_GRP_W-1:0]   last_grp;
    logic [L9_ADDR_W-1:0]  cur_addr;

    bram1_wr_addr_l9 u_addr (
        .x    (x),
        .y    (y),
        .g    (g),
        .addr (cur_addr)
    );

    // Accept decode and last-pixel detection for the latched group count.
    always_comb begin
        accept   = bus.in_valid & ready_q;
        last_grp = mode4_q ? L9_GRP_W'(L9_NGRP4 - 1) : L9_GRP_W'(L9_NGRP2 - 1);
        last_pix = (x == LAST_C) && (y == LAST_C) && (g == last_grp);
    end

    // Frame FSM, coordinate counters and one-stage write register.
    // NOTE: all state here uses non-blocking assignments so every register samples
    // pre-edge values; blocking ones would make the order of statements matter.
    always_ff @(posedge clk) begin
        // NOTE: reset is synchronous, so it is tested inside the clocked block and
        // only takes effect on a rising edge.
        if (rst) begin
            state   <= IDLE;
            x       <= '0;
            y       <= '0;
            g       <= '0;
            mode4_q <= 1'b0;
            ready_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
            we_q    <= 1'b0;
            addr_q  <= '0;
            din_q   <= '0;
        end else begin
            // NOTE: pulse outputs default low every cycle and are raised only by the
            // event that owns them, so a cycle without an accept never writes.
            we_q   <= 1'b0;
            done_q <= 1'b0;

            if (accept) begin
                we_q   <= 1'b1;
                addr_q <= cur_addr;
                din_q  <= bus.in_data;
            end

            case (state)
                IDLE: begin
                    if (bus.start) begin
                        state   <= RUN;
                        mode4_q <= bus.mode4;
                        x       <= '0;
                        y       <= '0;
                        g       <= '0;
                        err_q   <= 1'b0;
                        ready_q <= 1'b1;
                        busy_q  <= 1'b1;
                    end else if (bus.in_valid) begin
                        err_q <= 1'b1;
                    end
                end
                RUN: begin
                    if (accept) begin
                        if (last_pix) begin
                            state   <= DRAIN;
                            ready_q <= 1'b0;
                            x       <= '0;
                            y       <= '0;
                            g       <= '0;
                        end else if (y == LAST_C) begin
                            y <= '0;
                            if (x == LAST_C) begin
                                x <= '0;
                                g <= g + 1'b1;
                            end else begin
                                x <= x + 1'b1;
                            end
                        end else begin
                            y <= y + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    state  <= DONE;
                    busy_q <= 1'b0;
                    done_q <= 1'b1;
                end
                DONE: begin
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

    assign bus.in_ready   = ready_q;
    assign bus.bram1_we   = we_q;
    assign bus.bram1_addr = addr_q;
    assign bus.bram1_din  = din_q;
    assign bus.busy       = busy_q;
    assign bus.done       = done_q;
    assign bus.err        = err_q;

endmodule

// File: tb/tb_bram1_wr_seq_l9.sv
// Self-checking bench for the layer-9 BRAM1 write sequencer.
module tb_bram1_wr_seq_l9;

    localparam int DATA_W = 16;

    logic clk = 1'b0;
    logic rst;

    always #5 clk = ~clk;

    bram1_wr_seq_l9_if #(.DATA_W(DATA_W)) bus  ();
    bram1_wr_seq_l9_if #(.DATA_W(DATA_W)) bus1 ();

    bram1_wr_seq_l9 #(.DATA_W(DATA_W), .DIM(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    bram1_wr_seq_l9 #(.DATA_W(DATA_W), .DIM(1)) dut1 (
        .clk (clk),
        .rst (rst),
        .bus (bus1.slave)
    );

    int vectors     = 0;
    int miscompares = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Address of the k-th accepted pixel: y fastest, then x, then group.
    function automatic logic [9:0] ref_addr(input int dim, input int k);
        int per, gi, xi, yi;
        per = dim * dim;
        gi  = k / per;
        xi  = (k % per) / dim;
        yi  = k % dim;
        return 10'(xi * 32 + yi + 8 * gi);
    endfunction

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    // One DIM=8 frame; optional random gaps, mid-frame start/mode4 noise, abort.
    task automatic run_frame(input logic m4, input int gap_pct, input bit perturb,
                             input int abort_at);
        int          total, k, cyc;
        logic        acc;
        logic [15:0] d;
        total = 64 * (m4 ? 4 : 2);
        bus.start = 1'b1; bus.mode4 = m4; bus.in_valid = 1'b0;
        tick();
        bus.start = 1'b0;
        chk("start_busy",  bus.busy,     1);
        chk("start_ready", bus.in_ready, 1);
        chk("start_err",   bus.err,      0);
        chk("start_we",    bus.bram1_we, 0);
        k = 0; cyc = 0;
        while (k < total && cyc < 5000) begin
            if (abort_at >= 0 && k == abort_at) break;
            bus.in_valid = ($urandom_range(99) >= gap_pct);
            d            = 16'($urandom);
            bus.in_data  = d;
            if (perturb) begin
                bus.start = ($urandom_range(7) == 0);
                bus.mode4 = 1'($urandom_range(1));
            end
            chk("ready_run", bus.in_ready, 1);
            acc = bus.in_valid;
            tick();
            cyc++;
            chk("we", bus.bram1_we, acc);
            if (acc) begin
                chk("addr", bus.bram1_addr, ref_addr(8, k));
                chk("din",  bus.bram1_din,  d);
                k++;
            end
        end
        bus.start = 1'b0;
        bus.in_valid = 1'b0;
        if (cyc >= 5000) chk("frame_timeout", k, total);
        if (abort_at >= 0) begin
            rst = 1'b1; bus.in_valid = 1'b1;
            tick();
            rst = 1'b0; bus.in_valid = 1'b0;
            chk("abort_we",    bus.bram1_we,   0);
            chk("abort_busy",  bus.busy,       0);
            chk("abort_ready", bus.in_ready,   0);
            chk("abort_addr",  bus.bram1_addr, 0);
            return;
        end
        // DRAIN: offered pixels must be refused and must not raise err.
        bus.in_valid = 1'b1;
        chk("drain_ready", bus.in_ready, 0);
        chk("drain_busy",  bus.busy,     1);
        chk("drain_done",  bus.done,     0);
        tick();
        bus.in_valid = 1'b0;
        chk("done_we",    bus.bram1_we, 0);
        chk("done_pulse", bus.done,     1);
        chk("done_busy",  bus.busy,     0);
        chk("done_ready", bus.in_ready, 0);
        tick();
        chk("idle_done", bus.done,     0);
        chk("idle_err",  bus.err,      0);
        chk("idle_we",   bus.bram1_we, 0);
    endtask

    initial begin
        rst = 1'b1;
        bus.start = 1'b0;  bus.mode4 = 1'b0;  bus.in_valid = 1'b0;  bus.in_data = '0;
        bus1.start = 1'b0; bus1.mode4 = 1'b0; bus1.in_valid = 1'b0; bus1.in_data = '0;
        tick();
        tick();
        chk("rst_ready", bus.in_ready,   0);
        chk("rst_we",    bus.bram1_we,   0);
        chk("rst_addr",  bus.bram1_addr, 0);
        chk("rst_din",   bus.bram1_din,  0);
        chk("rst_busy",  bus.busy,       0);
        chk("rst_done",  bus.done,       0);
        chk("rst_err",   bus.err,        0);
        chk("rst1_we",   bus1.bram1_we,  0);
        rst = 1'b0;
        tick();

        // Two groups, continuous stream; final address {7,15}.
        run_frame(1'b0, 0, 1'b0, -1);
        chk("last_addr_m2", bus.bram1_addr, 10'h0EF);

        // Four groups, continuous stream; final address {7,31}.
        run_frame(1'b1, 0, 1'b0, -1);
        chk("last_addr_m4", bus.bram1_addr, 10'h0FF);

        // Random gaps in both group modes.
        run_frame(1'b1, 50, 1'b0, -1);
        run_frame(1'b0, 50, 1'b0, -1);

        // Abort after 37 accepts, then a fresh frame must restart at address 0.
        run_frame(1'b0, 30, 1'b0, 37);
        tick();
        run_frame(1'b0, 0, 1'b0, -1);

        // Mid-frame start pulses and mode4 toggles must not change the frame.
        run_frame(1'b0, 20, 1'b1, -1);
        run_frame(1'b1, 20, 1'b1, -1);

        // in_valid while IDLE: sticky err, no write; the next start clears it.
        bus.in_valid = 1'b1; bus.in_data = 16'hBEEF;
        tick();
        bus.in_valid = 1'b0;
        chk("idle_err_set",   bus.err,      1);
        chk("idle_err_we",    bus.bram1_we, 0);
        chk("idle_err_ready", bus.in_ready, 0);
        tick();
        chk("idle_err_sticky", bus.err,      1);
        chk("idle_err_nowe",   bus.bram1_we, 0);
        run_frame(1'b0, 10, 1'b0, -1);

        // DIM=1, four groups: one pixel per group.
        bus1.start = 1'b1; bus1.mode4 = 1'b1;
        tick();
        bus1.start = 1'b0;
        chk("d1_busy", bus1.busy, 1);
        for (int i = 0; i < 4; i++) begin
            bus1.in_valid = 1'b1;
            bus1.in_data  = 16'(16'h1000 + i);
            chk("d1_ready", bus1.in_ready, 1);
            tick();
            chk("d1_we",   bus1.bram1_we,   1);
            chk("d1_addr", bus1.bram1_addr, ref_addr(1, i));
            chk("d1_din",  bus1.bram1_din,  32'(16'h1000 + i));
        end
        bus1.in_valid = 1'b0;
        chk("d1_drain_ready", bus1.in_ready, 0);
        tick();
        chk("d1_done_we", bus1.bram1_we, 0);
        chk("d1_done",    bus1.done,     1);
        tick();
        chk("d1_idle_done", bus1.done, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
